// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU issue controller.
//   - opcode encodings (000..101 legal, 110/111 illegal)
//   - is_legal_op(): opcode legality test
//   - req_t: one queued request, packed as {op, cin, b, a} (12 bits)
//   - state_t: issue FSM state encoding
package alu4_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;

  localparam int REQ_W = 12;

  typedef struct packed {
    logic [2:0] op;
    logic       cin;
    logic [3:0] b;
    logic [3:0] a;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/alu4_req_fifo.sv
// Request FIFO for the ALU issue controller.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write request (ignored while full)
//   pop, rdata      read request (ignored while empty); rdata shows the head
//   full, empty     occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers
// that differ only in the wrap bit mean full.
module alu4_req_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push while full is refused even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until a push marks it valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu4_issue_ctrl.sv
// Issue sequencer around the 4-bit ALU.
// Buffers requests in a FIFO, drives one at a time onto registered ALU
// inputs, holds them SETTLE_CYCLES, captures the ALU result and offers it on
// a result port.
// Ports:
//   clk, rst                           clock, asynchronous active-high reset
//   in_valid/in_ready, in_a/b/cin/op   request input
//   alu_a/b/cin/op (out)               registered ALU operands
//   alu_out, alu_cout (in)             ALU result
//   res_valid/res_ready, res_data,     result output
//   res_cout, res_op, res_err
//   op_count                           completed result handshakes (wraps)
//   dbg_state                          current FSM state
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds valid and its data stable
// until that edge; ready never depends combinationally on valid.
module alu4_issue_ctrl
  import alu4_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_cin,
  input  logic [2:0] in_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic       alu_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_cout,
  output logic [2:0] res_op,
  output logic       res_err,
  output logic [7:0] op_count,
  output state_t     dbg_state
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            ready_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  req_t            push_req;
  req_t            head;
  logic [REQ_W-1:0] head_bits;

  // ready_q keeps in_ready low during reset and lets it rise on the first
  // clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign in_ready = ready_q && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_IDLE) && !fifo_empty;

  always_comb begin
    push_req     = '0;
    push_req.a   = in_a;
    push_req.b   = in_b;
    push_req.cin = in_cin;
    push_req.op  = in_op;
  end

  assign head = req_t'(head_bits);

  alu4_req_fifo #(
    .W     (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_op    <= '0;
      res_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (is_legal_op(head.op)) begin
              alu_a   <= head.a;
              alu_b   <= head.b;
              alu_cin <= head.cin;
              alu_op  <= head.op;
              cnt     <= CW'(SETTLE_CYCLES - 1);
              state   <= ST_SETTLE;
            end else begin
              // Illegal opcode: report an error straight away and leave the
              // ALU operands as they were.
              res_data  <= '0;
              res_cout  <= 1'b0;
              res_err   <= 1'b1;
              res_op    <= head.op;
              res_valid <= 1'b1;
              state     <= ST_RESULT;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            res_data  <= alu_out;
            res_cout  <= alu_cout;
            res_op    <= alu_op;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= ST_RESULT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_alu4_issue_ctrl.sv
module tb_alu4_issue_ctrl;
  import alu4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (SETTLE_CYCLES=1) ----------------
  logic       in_valid, in_ready, in_cin, alu_cin, alu_cout;
  logic [3:0] in_a, in_b, alu_a, alu_b;
  logic [2:0] in_op, alu_op, res_op;
  logic [7:0] alu_out, res_data, op_count;
  logic       res_valid, res_ready, res_cout, res_err;
  state_t     dbg_state;

  alu4_issue_ctrl #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout), .res_op(res_op),
    .res_err(res_err), .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- DUT (SETTLE_CYCLES=3) ----------------
  logic       in_valid3, in_ready3, in_cin3, alu_cin3, alu_cout3;
  logic [3:0] in_a3, in_b3, alu_a3, alu_b3;
  logic [2:0] in_op3, alu_op3, res_op3;
  logic [7:0] alu_out3, res_data3, op_count3;
  logic       res_valid3, res_ready3, res_cout3, res_err3;
  state_t     dbg_state3;

  alu4_issue_ctrl #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .in_a(in_a3), .in_b(in_b3), .in_cin(in_cin3), .in_op(in_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_cin(alu_cin3), .alu_op(alu_op3),
    .alu_out(alu_out3), .alu_cout(alu_cout3),
    .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .res_cout(res_cout3), .res_op(res_op3),
    .res_err(res_err3), .op_count(op_count3), .dbg_state(dbg_state3)
  );

  // ---------------- behavioural ALU ----------------
  // Returns {cout, out}. Illegal opcodes yield garbage the DUT must ignore.
  function automatic logic [8:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin, input logic [2:0] op);
    logic [4:0] s;
    logic [7:0] o;
    logic       c;
    s = '0;
    o = '0;
    c = 1'b0;
    case (op)
      OP_ADD:  begin s = {1'b0, a} + {1'b0, b} + {4'b0, cin}; o = {3'b0, s}; c = s[4]; end
      OP_SUB:  begin s = {1'b0, a} - {1'b0, b} - {4'b0, cin}; o = {4'b0, s[3:0]}; c = s[4]; end
      OP_SHL:  o = {4'b0, a} << b[1:0];
      OP_MUL:  o = {4'b0, a} * {4'b0, b};
      OP_XNOR: o = {4'b0, ~(a ^ b)};
      OP_CMP:  begin o = {7'b0, (a < b)}; c = (a == b); end
      default: begin o = 8'hAA; c = 1'b1; end
    endcase
    return {c, o};
  endfunction

  always_comb {alu_cout, alu_out}   = alu_model(alu_a, alu_b, alu_cin, alu_op);
  always_comb {alu_cout3, alu_out3} = alu_model(alu_a3, alu_b3, alu_cin3, alu_op3);

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected result bytes of {err, cout, op, data}
  logic [12:0] exp_q[$];
  logic        sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {51'b0, res_err, res_cout, res_op, res_data}, 64'h1FFF);
      end else begin
        check("sb_result", {51'b0, res_err, res_cout, res_op, res_data}, {51'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_req(input logic [3:0] a, input logic [3:0] b,
                           input logic cin, input logic [2:0] op);
    in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1;
  endtask

  task automatic wait_res_valid(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    check(name, {63'b0, res_valid}, 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    check(name, exp_q.size(), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return {in_ready, alu_a, alu_b, alu_cin, alu_op, res_valid, res_data,
            res_cout, res_op, res_err, op_count, dbg_state};
  endfunction

  function automatic logic [63:0] all_outs3();
    return {in_ready3, alu_a3, alu_b3, alu_cin3, alu_op3, res_valid3, res_data3,
            res_cout3, res_op3, res_err3, op_count3, dbg_state3};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [2:0] op;
    logic [7:0] exp_data;
    logic       exp_cout;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    int n;
    logic seen;
    logic [3:0] last_a, last_b;
    logic       last_cin;
    logic [2:0] last_op;
    logic [8:0] m;

    vecs[0]  = '{4'h3, 4'h5, 1'b0, OP_ADD,  8'h08, 1'b0, 1'b0, 2};
    vecs[1]  = '{4'hF, 4'hF, 1'b1, OP_ADD,  8'h1F, 1'b1, 1'b0, 2};
    vecs[2]  = '{4'h9, 4'h4, 1'b0, OP_SUB,  8'h05, 1'b0, 1'b0, 2};
    vecs[3]  = '{4'h2, 4'h5, 1'b1, OP_SUB,  8'h0C, 1'b1, 1'b0, 2};
    vecs[4]  = '{4'h3, 4'h2, 1'b0, OP_SHL,  8'h0C, 1'b0, 1'b0, 2};
    vecs[5]  = '{4'hF, 4'h3, 1'b0, OP_SHL,  8'h78, 1'b0, 1'b0, 2};
    vecs[6]  = '{4'hF, 4'hF, 1'b0, OP_MUL,  8'hE1, 1'b0, 1'b0, 2};
    vecs[7]  = '{4'h7, 4'h6, 1'b0, OP_MUL,  8'h2A, 1'b0, 1'b0, 2};
    vecs[8]  = '{4'hA, 4'h5, 1'b0, OP_XNOR, 8'h00, 1'b0, 1'b0, 2};
    vecs[9]  = '{4'hC, 4'hA, 1'b0, OP_XNOR, 8'h09, 1'b0, 1'b0, 2};
    vecs[10] = '{4'h2, 4'h7, 1'b0, OP_CMP,  8'h01, 1'b0, 1'b0, 2};
    vecs[11] = '{4'h6, 4'h6, 1'b0, OP_CMP,  8'h00, 1'b1, 1'b0, 2};
    vecs[12] = '{4'h1, 4'h2, 1'b1, 3'b110,  8'h00, 1'b0, 1'b1, 1};
    vecs[13] = '{4'hF, 4'hF, 1'b0, 3'b111,  8'h00, 1'b0, 1'b1, 1};

    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_op = 0; res_ready = 0;
    in_valid3 = 0; in_a3 = 0; in_b3 = 0; in_cin3 = 0; in_op3 = 0; res_ready3 = 1;

    // ---- reset ----
    #1 rst = 1'b1;
    #2;
    check("reset_outs", all_outs(), 64'd0);
    check("reset_outs3", all_outs3(), 64'd0);
    tick(); tick();
    rst = 1'b0;
    check("in_ready_before_clk", {63'b0, in_ready}, 64'd0);
    tick();
    check("in_ready_after_clk", {63'b0, in_ready}, 64'd1);

    // ---- table-driven single ops, res_ready held high ----
    res_ready = 1'b1;
    last_a = 0; last_b = 0; last_cin = 0; last_op = 0;
    for (int i = 0; i < 14; i++) begin
      drive_req(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
      check($sformatf("v%0d_in_ready", i), {63'b0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 20) begin tick(); lat++; end
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_data", i), res_data, vecs[i].exp_data);
      check($sformatf("v%0d_cout", i), {63'b0, res_cout}, {63'b0, vecs[i].exp_cout});
      check($sformatf("v%0d_err", i), {63'b0, res_err}, {63'b0, vecs[i].exp_err});
      check($sformatf("v%0d_op", i), res_op, vecs[i].op);
      if (!vecs[i].exp_err) begin
        last_a = vecs[i].a; last_b = vecs[i].b; last_cin = vecs[i].cin; last_op = vecs[i].op;
      end
      check($sformatf("v%0d_alu_regs", i), {alu_a, alu_b, alu_cin, alu_op},
            {last_a, last_b, last_cin, last_op});
      tick();
      check($sformatf("v%0d_valid_drop", i), {63'b0, res_valid}, 64'd0);
    end
    check("op_count_table", op_count, 64'd14);

    // ---- FIFO full: hold one result, fill the queue, 5th refused ----
    sb_en = 1'b1;
    res_ready = 1'b0;
    drive_req(4'h1, 4'h1, 1'b0, OP_ADD); exp_q.push_back({2'b00, OP_ADD, 8'h02});
    tick();
    in_valid = 1'b0;
    wait_res_valid("full_p0_valid");
    drive_req(4'h3, 4'h3, 1'b0, OP_MUL); exp_q.push_back({2'b00, OP_MUL, 8'h09});
    check("full_acc0", {63'b0, in_ready}, 64'd1); tick();
    drive_req(4'h8, 4'h1, 1'b0, OP_SUB); exp_q.push_back({2'b00, OP_SUB, 8'h07});
    check("full_acc1", {63'b0, in_ready}, 64'd1); tick();
    drive_req(4'hF, 4'h0, 1'b0, OP_XNOR); exp_q.push_back({2'b00, OP_XNOR, 8'h00});
    check("full_acc2", {63'b0, in_ready}, 64'd1); tick();
    drive_req(4'h1, 4'h3, 1'b0, OP_SHL); exp_q.push_back({2'b00, OP_SHL, 8'h08});
    check("full_acc3", {63'b0, in_ready}, 64'd1); tick();
    drive_req(4'h1, 4'h2, 1'b0, OP_CMP);
    check("full_refuse", {63'b0, in_ready}, 64'd0);
    tick(); tick(); tick();
    check("full_refuse_hold", {63'b0, in_ready}, 64'd0);
    exp_q.push_back({2'b00, OP_CMP, 8'h01});
    res_ready = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin seen = in_ready; tick(); n++; end
    in_valid = 1'b0;
    check("full_5th_accepted", {63'b0, seen}, 64'd1);
    wait_drain("full_drain");
    tick(); tick();
    check("op_count_full", op_count, 64'd20);

    // ---- backpressure: result and operands held for 10 clocks ----
    res_ready = 1'b0;
    drive_req(4'h9, 4'h4, 1'b0, OP_SUB); exp_q.push_back({2'b00, OP_SUB, 8'h05});
    tick();
    in_valid = 1'b0;
    wait_res_valid("bp_valid");
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_hold%0d", c),
            {res_valid, res_data, res_op, res_err, alu_a, alu_b, alu_op},
            {1'b1, 8'h05, OP_SUB, 1'b0, 4'h9, 4'h4, OP_SUB});
      tick();
    end
    res_ready = 1'b1;
    wait_drain("bp_drain");
    tick();
    check("op_count_bp", op_count, 64'd21);
    sb_en = 1'b0;

    // ---- reset during SETTLE with 3 ops queued ----
    res_ready = 1'b0;
    drive_req(4'h2, 4'h2, 1'b0, OP_ADD); tick();
    in_valid = 1'b0;
    wait_res_valid("rst_hold_valid");
    for (int k = 0; k < 4; k++) begin
      drive_req(4'(k), 4'h1, 1'b0, OP_ADD);
      tick();
    end
    in_valid = 1'b0;
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    n = 0;
    while (dbg_state != ST_SETTLE && n < 20) begin tick(); n++; end
    check("rst_reach_settle", {62'b0, dbg_state}, {62'b0, ST_SETTLE});
    rst = 1'b1;
    #1;
    check("rst_mid_outs", all_outs(), 64'd0);
    tick(); tick();
    rst = 1'b0;
    res_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    check("rst_no_result", {63'b0, seen}, 64'd0);
    check("rst_op_count", op_count, 64'd0);

    // ---- SETTLE_CYCLES=3: latency and op_count wrap over 256 ops ----
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      in_a3 = iv[3:0]; in_b3 = iv[7:4]; in_cin3 = iv[0]; in_op3 = 3'(i % 6);
      in_valid3 = 1'b1;
      if (i == 255) check("s3_count_255", op_count3, 64'd255);
      tick();
      in_valid3 = 1'b0;
      lat = 0;
      while (!res_valid3 && lat < 20) begin tick(); lat++; end
      check($sformatf("s3_lat%0d", i), lat, 64'd4);
      m = alu_model(iv[3:0], iv[7:4], iv[0], 3'(i % 6));
      check($sformatf("s3_res%0d", i), {res_cout3, res_data3}, {55'b0, m});
      tick();
    end
    check("s3_count_wrap", op_count3, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
